// File: rtl/generador_nonce_multi.sv
// generador_nonce_multi: splits the inclusive nonce range [nonce_ini, nonce_fin]
// across N_CH hash-core channels by striding (channel i issues nonce_ini+i,
// nonce_ini+i+N_CH, ...). Stops on the first hit, on exhaustion or on abort.
// Latency: channel i presents its first nonce the cycle after start; a
// handshake advances that channel by N_CH at the same edge. The run ends one
// edge after the last channel finishes, or at the edge that samples a hit.
// Backpressure: per-channel valid/ready; a stalled channel holds its nonce and
// valid and never stalls the other channels.
// Ports:
//   clk, reset_L            clock (rising edge) / async active-low reset
//   start, nonce_ini/fin    load a new range (honoured in IDLE or DONE only)
//   abort                   cancel the current run, back to IDLE, no done
//   ch_valid/ch_ready/ch_nonce  per-channel candidate handshake
//   hit, hit_nonce          per-channel match report (lowest index wins)
//   busy, done, found, found_nonce  run status and result
// Optional build macro NONCE_CNT_EN adds output intentos: a saturating 32-bit
// count of handshakes in the current run.
module generador_nonce_multi #(
  parameter int NONCE_W = 24,
  parameter int N_CH    = 4
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      start,
  input  logic [NONCE_W-1:0]        nonce_ini,
  input  logic [NONCE_W-1:0]        nonce_fin,
  input  logic                      abort,
  input  logic [N_CH-1:0]           ch_ready,
  output logic [N_CH-1:0]           ch_valid,
  output logic [N_CH*NONCE_W-1:0]   ch_nonce,
  input  logic [N_CH-1:0]           hit,
  input  logic [N_CH*NONCE_W-1:0]   hit_nonce,
  output logic                      busy,
  output logic                      done,
  output logic                      found,
  output logic [NONCE_W-1:0]        found_nonce
`ifdef NONCE_CNT_EN
  ,
  output logic [31:0]               intentos
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The stride is widened to NONCE_W+1 bits so that every sum keeps its carry;
  // a carry always compares greater than the zero-extended nonce_fin.
  localparam logic [NONCE_W:0] STRIDE = (NONCE_W+1)'(N_CH);

  state_t             state;
  logic [NONCE_W-1:0] cur [N_CH];
  logic [NONCE_W-1:0] fin_q;

  logic [NONCE_W:0]   load_sum [N_CH];
  logic [NONCE_W:0]   adv_sum  [N_CH];
  logic [N_CH-1:0]    hs;
  logic [NONCE_W-1:0] win_nonce;

  always_comb begin
    hs = ch_valid & ch_ready;
    for (int i = 0; i < N_CH; i++) begin
      load_sum[i] = {1'b0, nonce_ini} + (NONCE_W+1)'(i);
      adv_sum[i]  = {1'b0, cur[i]} + STRIDE;
    end
  end

  // Priority pick: scanning from the top down leaves the lowest asserted index.
  always_comb begin
    win_nonce = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hit[i]) win_nonce = hit_nonce[i*NONCE_W +: NONCE_W];
    end
  end

  always_comb begin
    ch_nonce = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_nonce[i*NONCE_W +: NONCE_W] = cur[i];
    end
  end

`ifdef NONCE_CNT_EN
  logic [31:0] hs_cnt;
  logic [32:0] cnt_sum;

  always_comb begin
    hs_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      hs_cnt = hs_cnt + 32'(hs[i]);
    end
    cnt_sum = {1'b0, intentos} + {1'b0, hs_cnt};
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      intentos <= '0;
    end else if ((state != S_RUN) && start) begin
      intentos <= '0;
    end else if (state == S_RUN) begin
      intentos <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      ch_valid    <= '0;
      fin_q       <= '0;
      for (int i = 0; i < N_CH; i++) cur[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RUN;
            busy        <= 1'b1;
            found       <= 1'b0;
            found_nonce <= '0;
            fin_q       <= nonce_fin;
            for (int i = 0; i < N_CH; i++) begin
              cur[i]      <= load_sum[i][NONCE_W-1:0];
              ch_valid[i] <= (load_sum[i] <= {1'b0, nonce_fin});
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            ch_valid <= '0;
            for (int i = 0; i < N_CH; i++) cur[i] <= '0;
          end else if (|hit) begin
            // Handshakes in this cycle still count; the channels simply stop.
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            found       <= 1'b1;
            found_nonce <= win_nonce;
            ch_valid    <= '0;
          end else if (ch_valid == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            for (int i = 0; i < N_CH; i++) begin
              if (hs[i]) begin
                if (adv_sum[i] <= {1'b0, fin_q}) cur[i] <= adv_sum[i][NONCE_W-1:0];
                else                             ch_valid[i] <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_nonce_multi.sv
module tb_generador_nonce_multi;

  localparam int W = 24;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset_L;
  logic             start;
  logic [W-1:0]     nonce_ini;
  logic [W-1:0]     nonce_fin;
  logic             abort;
  logic [N-1:0]     ch_ready;
  logic [N-1:0]     ch_valid;
  logic [N*W-1:0]   ch_nonce;
  logic [N-1:0]     hit;
  logic [N*W-1:0]   hit_nonce;
  logic             busy;
  logic             done;
  logic             found;
  logic [W-1:0]     found_nonce;
`ifdef NONCE_CNT_EN
  logic [31:0]      intentos;
`endif

  int errors = 0;
  int checks = 0;
  int exp_q [N][$];

  always #5 clk = ~clk;

  generador_nonce_multi #(.NONCE_W(W), .N_CH(N)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .start       (start),
    .nonce_ini   (nonce_ini),
    .nonce_fin   (nonce_fin),
    .abort       (abort),
    .ch_ready    (ch_ready),
    .ch_valid    (ch_valid),
    .ch_nonce    (ch_nonce),
    .hit         (hit),
    .hit_nonce   (hit_nonce),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .found_nonce (found_nonce)
`ifdef NONCE_CNT_EN
    ,
    .intentos    (intentos)
`endif
  );

  function automatic logic [W-1:0] nonce_of(input int i);
    return ch_nonce[i*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one range to completion. The reference is the list of nonces each
  // channel must issue, in order, derived directly from the striding rule.
  task automatic run_range(input int ini, input int fin, input int exp_done_cyc,
                           input bit stall1);
    int total;
    int issued;
    int done_cyc;
    logic [N-1:0] rdy;
    total = (fin >= ini) ? (fin - ini + 1) : 0;
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      for (int v = ini + i; v <= fin; v += N) exp_q[i].push_back(v);
    end
    start = 1'b1; nonce_ini = W'(ini); nonce_fin = W'(fin);
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("found_cleared", found, 0);
    chk("found_nonce_cleared", found_nonce, 0);
    issued = 0;
    done_cyc = -1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (stall1) begin
        rdy = '1;
        if (cyc < 5) begin
          rdy[1] = 1'b0;
          chk("stall_valid1", ch_valid[1], 1);
          chk("stall_nonce1", nonce_of(1), W'(ini + 1));
        end
      end else if (exp_done_cyc >= 0) begin
        rdy = '1;
      end else begin
        rdy = N'($urandom);
      end
      // A start pulse while running must have no effect.
      if (cyc == 1) begin start = 1'b1; nonce_ini = W'(ini + 3); end
      else          start = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (ch_valid[i] && rdy[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("extra_nonce_ch%0d", i), {40'h0, nonce_of(i)}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            chk($sformatf("nonce_ch%0d", i), nonce_of(i), exp_q[i].pop_front());
            issued++;
          end
        end
      end
      ch_ready = rdy;
      step();
      if (done) begin done_cyc = cyc; break; end
    end
    start = 1'b0;
    ch_ready = '0;
    chk("run_ended", done_cyc >= 0, 1);
    if (exp_done_cyc >= 0) chk("done_latency", done_cyc, exp_done_cyc);
    chk("all_issued", issued, total);
    chk("end_found", found, 0);
    chk("end_busy", busy, 0);
    chk("end_valid", ch_valid, 0);
`ifdef NONCE_CNT_EN
    chk("intentos_run", intentos, total);
`endif
    step();
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_hit(input int ini, input logic [N-1:0] hmask,
                         input logic [N*W-1:0] hn, input int pre);
    logic [W-1:0] exp_win;
    logic [N*W-1:0] other;
    exp_win = '0;
    for (int i = 0; i < N; i++) begin
      if (hmask[i]) begin exp_win = hn[i*W +: W]; break; end
    end
    start = 1'b1; nonce_ini = W'(ini); nonce_fin = W'(ini + 1000);
    step();
    start = 1'b0;
    ch_ready = '1;
    for (int c = 0; c < pre; c++) step();
    hit = hmask; hit_nonce = hn;
    step();
    hit = '0; ch_ready = '0;
    chk("hit_found", found, 1);
    chk("hit_found_nonce", found_nonce, exp_win);
    chk("hit_done", done, 1);
    chk("hit_valid_clear", ch_valid, 0);
    chk("hit_busy", busy, 0);
`ifdef NONCE_CNT_EN
    chk("hit_intentos", intentos, N * (pre + 1));
`endif
    step();
    chk("hit_done_pulse", done, 0);
    chk("hit_found_hold", found, 1);
    // Hits arriving outside RUN are ignored.
    other = {$urandom, $urandom, $urandom};
    hit = '1; hit_nonce = other;
    step();
    hit = '0;
    chk("hit_ignored_done", done, 0);
    chk("hit_ignored_nonce", found_nonce, exp_win);
  endtask

  initial begin
    logic [N*W-1:0] hn;
    int ini;
    int fin;
    reset_L = 1'b0; start = 1'b0; abort = 1'b0; nonce_ini = '0; nonce_fin = '0;
    ch_ready = '0; hit = '0; hit_nonce = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_found_nonce", found_nonce, 0);
    chk("rst_valid", ch_valid, 0);
    chk("rst_nonce", ch_nonce, 0);
`ifdef NONCE_CNT_EN
    chk("rst_intentos", intentos, 0);
`endif
    reset_L = 1'b1;
    step();

    // Basic range, all channels ready.
    run_range(0, 9, 3, 1'b0);
    // Same range with channel 1 stalled for five cycles.
    run_range(0, 9, -1, 1'b1);

    // Directed hit: lowest index wins.
    hn = '0;
    hn[1*W +: W] = 24'h000041;
    hn[2*W +: W] = 24'h000042;
    run_hit(24'h40, 4'b0110, hn, 1);

    // Top of the nonce space: no wrap to zero.
    run_range(24'hFFFFFE, 24'hFFFFFF, -1, 1'b0);
    // Empty range.
    run_range(10, 5, 0, 1'b0);

    // Randomized ranges with random backpressure.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 2) == 0) ini = 24'hFFFFFF - int'($urandom_range(0, 20));
      else                           ini = int'($urandom_range(0, 5000));
      fin = ini + int'($urandom_range(0, 30));
      if (fin > 24'hFFFFFF) fin = 24'hFFFFFF;
      run_range(ini, fin, -1, 1'b0);
    end

    // Randomized hits.
    for (int k = 0; k < 4; k++) begin
      hn = {$urandom, $urandom, $urandom};
      run_hit(int'($urandom_range(0, 100000)), N'($urandom_range(1, 15)), hn,
              int'($urandom_range(0, 4)));
    end

    // Abort mid-run.
    start = 1'b1; nonce_ini = '0; nonce_fin = W'(5000);
    step();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin ch_ready = N'($urandom); step(); end
    abort = 1'b1;
    step();
    abort = 1'b0; ch_ready = '0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", ch_valid, 0);
    chk("abort_nonce", ch_nonce, 0);
    chk("abort_found", found, 0);
    chk("abort_found_nonce", found_nonce, 0);
    step();
    chk("abort_no_done", done, 0);
    chk("abort_idle", busy, 0);

    // Asynchronous reset mid-run.
    start = 1'b1; nonce_ini = W'(100); nonce_fin = W'(5000);
    step();
    start = 1'b0; ch_ready = '1;
    step(); step();
    chk("pre_reset_busy", busy, 1);
    reset_L = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", ch_valid, 0);
    chk("arst_nonce", ch_nonce, 0);
    chk("arst_done", done, 0);
    chk("arst_found", found, 0);
`ifdef NONCE_CNT_EN
    chk("arst_intentos", intentos, 0);
`endif
    step();
    reset_L = 1'b1; ch_ready = '0;
    step();
    chk("post_reset_done", done, 0);
    chk("post_reset_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/generador_nonce_multi.md
Name: generador_nonce_multi

Overview:
Parametrised successor of the single-stream 24-bit nonce generator. Splits an inclusive nonce range [nonce_ini, nonce_fin] across N_CH hash-core channels by striding: channel i issues nonce_ini+i, nonce_ini+i+N_CH, and so on. Each channel has its own valid/ready handshake. The block stops on the first reported hit, on range exhaustion, or on abort. It sits between the mining controller and the parallel hash cores.

Parameters:
NONCE_W, 24, nonce width in bits (>=8)
N_CH, 4, number of hash-core channels (>=1)

Ports:
clk  in  1  system clock, rising edge
reset_L  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; loads the range; honoured only in IDLE or DONE
nonce_ini  in  NONCE_W  first nonce of the range
nonce_fin  in  NONCE_W  last nonce of the range (inclusive)
abort  in  1  cancels a run
ch_ready  in  N_CH  channel i accepts ch_nonce[i]
ch_valid  out  N_CH  channel i presents a candidate
ch_nonce  out  N_CH*NONCE_W  channel i value at bits [i*NONCE_W +: NONCE_W]
hit  in  N_CH  channel i reports a match
hit_nonce  in  N_CH*NONCE_W  nonce matched by channel i (same packing as ch_nonce)
busy  out  1  high in RUN
done  out  1  one-cycle pulse at the end of a run
found  out  1  last run ended on a hit; held until the next start
found_nonce  out  NONCE_W  winning nonce; held until the next start

Behaviour:
- Reset (reset_L=0, asynchronous): state IDLE; all outputs 0; all channel registers 0.
- States:
  - IDLE: start -> RUN.
  - RUN: hit -> DONE. All channels finished -> DONE. abort -> IDLE.
  - DONE: start -> RUN.
- Start accepted at edge T:
  - found and found_nonce clear.
  - At T, channel i loads nonce_ini+i and sets ch_valid[i]=1 iff that value <= nonce_fin. Otherwise the channel is marked finished.
- Range arithmetic: all sums and compares use NONCE_W+1 bits. A carry out of NONCE_W, or a value > nonce_fin, marks the channel finished. Nonces never wrap to 0.
- Handshake, per channel:
  - While ch_valid[i]=1 and ch_ready[i]=0, ch_nonce[i] and ch_valid[i] are held stable.
  - When ch_valid[i] & ch_ready[i] at edge E, the channel advances by N_CH at E. If the new value exceeds the range, ch_valid[i] drops at E.
  - Channels are fully independent; a stalled channel does not stall the others.
- Exhaustion: in RUN, all channels finished and no hit -> DONE at the next edge. done=1 for exactly one cycle; found=0.
- Hit:
  - hit is sampled only in RUN and ignored in IDLE and DONE.
  - Among asserted hit bits, the lowest index wins. found_nonce <= its hit_nonce; found <= 1.
  - All ch_valid clear at the same edge; state -> DONE; done pulses one cycle.
- Simultaneous events:
  - Hit plus handshake in the same cycle: the handshake completes (counted), then the block stops.
  - abort has priority over hit and exhaustion: return to IDLE with no done pulse; found stays 0.
  - start is ignored in RUN.
- Empty range (nonce_ini > nonce_fin): no ch_valid is ever asserted. Enters RUN at T, DONE at T+1; done pulse in the cycle after T+1.
- Reset asserted mid-run: immediate return to reset values; no done pulse.
- busy = (state == RUN), registered with the state.

Optional Feature:
NONCE_CNT_EN:
- Defined: adds output port intentos (32 bits). Clears on accepted start; increments by popcount(ch_valid & ch_ready) each cycle; saturates at 0xFFFFFFFF; holds in DONE and IDLE; reset value 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. NONCE_W=24, N_CH=4; start with ini=0, fin=9; ch_ready=4'hF -> ch0 issues 0,4,8; ch1 1,5,9; ch2 2,6; ch3 3,7. Then one done pulse, found=0, intentos=10 (with NONCE_CNT_EN).
2. Same range with ch_ready[1]=0 for 5 cycles -> ch_nonce[1] holds 0x000001 with valid=1 throughout; other channels keep advancing; all 10 nonces are issued in total.
3. In RUN, hit=4'b0110 with hit_nonce[1]=0x000041 and hit_nonce[2]=0x000042 -> found_nonce=0x000041, found=1; next cycle ch_valid=0 and done pulses once.
4. ini=0xFFFFFE, fin=0xFFFFFF -> ch0 issues 0xFFFFFE and ch1 issues 0xFFFFFF once each; ch2 and ch3 are never valid; no 0x000000 ever appears; run ends with done and found=0.
5. ini=10, fin=5 -> ch_valid stays 0; busy high for one cycle; done pulses; found=0.
6. Abort mid-run -> IDLE, outputs 0, no done pulse. Separately, reset_L=0 mid-run asynchronously clears all outputs before the next clock edge.
